// File: rtl/pipe_hazard_if.sv
// pipe_hazard_if: hazard-control signal bundle between the core datapath and pipe_hazard_ctrl
interface pipe_hazard_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic             ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MemAccessM, mem_ready;
    logic             en_pc, en_fd, en_de, en_em;
    logic             flush_fd, flush_de, flush_mw;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             err;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
        output ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MemAccessM, mem_ready,
        input  en_pc, en_fd, en_de, en_em, flush_fd, flush_de, flush_mw,
        input  ForwardAE, ForwardBE, err, stall_cycles
    );

    modport slave (
        input  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
        input  ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MemAccessM, mem_ready,
        output en_pc, en_fd, en_de, en_em, flush_fd, flush_de, flush_mw,
        output ForwardAE, ForwardBE, err, stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: forwarding, stall/flush control and memory wait-state sequencing for a 5-stage pipeline
module pipe_hazard_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W = 32
) (
    input logic          clk,
    input logic          reset,
    pipe_hazard_if.slave hz
);
    typedef enum logic [1:0] {RUN = 2'd0, MEMWAIT = 2'd1, ERROR = 2'd2} state_t;

    localparam logic [6:0] CTL_NORMAL = 7'b1111_000;
    localparam logic [6:0] CTL_MEM    = 7'b0000_001;
    localparam logic [6:0] CTL_BRANCH = 7'b1111_110;
    localparam logic [6:0] CTL_LOAD   = 7'b0011_010;

    state_t           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic             lw_stall, mem_stall;
    logic [6:0]       ctl;

    assign lw_stall  = hz.ResultSrcE0 && hz.rdE != 5'd0 && (hz.rs1D == hz.rdE || hz.rs2D == hz.rdE);
    assign mem_stall = hz.MemAccessM && !hz.mem_ready;

    // Operand forwarding: M is the younger producer and wins over W; x0 is never forwarded
    always_comb begin
        hz.ForwardAE = (hz.rs1E != 5'd0 && hz.RegWriteM && hz.rs1E == hz.rdM) ? 2'b10 :
                       (hz.rs1E != 5'd0 && hz.RegWriteW && hz.rs1E == hz.rdW) ? 2'b01 : 2'b00;
        hz.ForwardBE = (hz.rs2E != 5'd0 && hz.RegWriteM && hz.rs2E == hz.rdM) ? 2'b10 :
                       (hz.rs2E != 5'd0 && hz.RegWriteW && hz.rs2E == hz.rdW) ? 2'b01 : 2'b00;
    end

    // Enables/flushes {en_pc,en_fd,en_de,en_em,flush_fd,flush_de,flush_mw} by hazard priority
    always_comb begin
        ctl = reset              ? CTL_NORMAL :
              state_q == ERROR   ? 7'b0 :
              mem_stall          ? CTL_MEM :
              hz.PCSrcE          ? CTL_BRANCH :
              lw_stall           ? CTL_LOAD : CTL_NORMAL;
    end

    assign {hz.en_pc, hz.en_fd, hz.en_de, hz.en_em, hz.flush_fd, hz.flush_de, hz.flush_mw} = ctl;
    assign hz.err          = state_q == ERROR;
    assign hz.stall_cycles = stall_cycles_q;

    // Wait-state sequencing and saturating stall accounting
    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        stall_cycles_d = (ctl[6:3] != 4'hF && stall_cycles_q != '1) ? stall_cycles_q + CNT_W'(1) : stall_cycles_q;
        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d    = MEMWAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            MEMWAIT: begin
                if (!hz.MemAccessM || hz.mem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = 8'd0;
                end else if (wait_cnt_q == 8'(TIMEOUT_CYCLES)) begin
                    state_d = ERROR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: state_d = ERROR;
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= RUN;
            wait_cnt_q     <= 8'd0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and randomized checks of pipe_hazard_ctrl against a rule-level model
module tb_pipe_hazard_ctrl;
    localparam int TA = 64;
    localparam int TB = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [4:0] rs1D = '0, rs2D = '0, rs1E = '0, rs2E = '0, rdE = '0, rdM = '0, rdW = '0;
    logic ResultSrcE0 = 0, RegWriteM = 0, RegWriteW = 0, PCSrcE = 0, MemAccessM = 0, mem_ready = 0;

    pipe_hazard_if #(.CNT_W(32)) ifa ();
    pipe_hazard_if #(.CNT_W(4))  ifb ();

    assign {ifa.rs1D, ifa.rs2D, ifa.rs1E, ifa.rs2E, ifa.rdE, ifa.rdM, ifa.rdW} = {rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW};
    assign {ifb.rs1D, ifb.rs2D, ifb.rs1E, ifb.rs2E, ifb.rdE, ifb.rdM, ifb.rdW} = {rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW};
    assign {ifa.ResultSrcE0, ifa.RegWriteM, ifa.RegWriteW, ifa.PCSrcE, ifa.MemAccessM, ifa.mem_ready} =
           {ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MemAccessM, mem_ready};
    assign {ifb.ResultSrcE0, ifb.RegWriteM, ifb.RegWriteW, ifb.PCSrcE, ifb.MemAccessM, ifb.mem_ready} =
           {ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MemAccessM, mem_ready};

    pipe_hazard_ctrl #(.TIMEOUT_CYCLES(TA), .CNT_W(32)) dut_a (.clk(clk), .reset(reset), .hz(ifa.slave));
    pipe_hazard_ctrl #(.TIMEOUT_CYCLES(TB), .CNT_W(4))  dut_b (.clk(clk), .reset(reset), .hz(ifb.slave));

    logic [6:0] ctl_a, ctl_b;
    assign ctl_a = {ifa.en_pc, ifa.en_fd, ifa.en_de, ifa.en_em, ifa.flush_fd, ifa.flush_de, ifa.flush_mw};
    assign ctl_b = {ifb.en_pc, ifb.en_fd, ifb.en_de, ifb.en_em, ifb.flush_fd, ifb.flush_de, ifb.flush_mw};

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: error flag, consecutive memory-stall run length and stall totals
    bit          m_err_a = 0, m_err_b = 0;
    int          m_run_a = 0, m_run_b = 0;
    logic [31:0] m_cnt_a = '0;
    logic [3:0]  m_cnt_b = '0;

    function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
        if (rs != 0 && RegWriteM && rs == rdM) return 2'b10;
        if (rs != 0 && RegWriteW && rs == rdW) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [6:0] exp_ctl(input bit e);
        bit lw;
        lw = ResultSrcE0 && rdE != 0 && (rs1D == rdE || rs2D == rdE);
        if (reset) return 7'b1111_000;
        if (e) return 7'b0000_000;
        if (MemAccessM && !mem_ready) return 7'b0000_001;
        if (PCSrcE) return 7'b1111_110;
        if (lw) return 7'b0011_010;
        return 7'b1111_000;
    endfunction

    function automatic bit any_disabled(input bit e);
        logic [6:0] c;
        c = exp_ctl(e);
        return c[6:3] != 4'hF;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_err_a <= 0; m_err_b <= 0; m_run_a <= 0; m_run_b <= 0; m_cnt_a <= '0; m_cnt_b <= '0;
        end else begin
            if (any_disabled(m_err_a) && m_cnt_a != 32'hFFFF_FFFF) m_cnt_a <= m_cnt_a + 1;
            if (any_disabled(m_err_b) && m_cnt_b != 4'hF) m_cnt_b <= m_cnt_b + 1;
            if (!m_err_a) begin
                m_run_a <= (MemAccessM && !mem_ready) ? m_run_a + 1 : 0;
                if (MemAccessM && !mem_ready && m_run_a + 1 > TA) m_err_a <= 1;
            end
            if (!m_err_b) begin
                m_run_b <= (MemAccessM && !mem_ready) ? m_run_b + 1 : 0;
                if (MemAccessM && !mem_ready && m_run_b + 1 > TB) m_err_b <= 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        {rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW} = '0;
        {ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MemAccessM, mem_ready} = '0;
    endtask

    task automatic do_reset();
        set_idle();
        step();
        reset = 1;
        #2;
        reset = 0;
        step();
    endtask

    task automatic test_reset();
        MemAccessM = 1; mem_ready = 0; PCSrcE = 1; rs1E = 5; rdM = 5; RegWriteM = 1;
        #3;
        n_cmp++; if (ctl_a !== 7'b1111_000) begin n_bad++; $display("FAIL reset_ctl: got %b expected %b", ctl_a, 7'b1111_000); end
        n_cmp++; if (ifa.stall_cycles !== 32'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d expected 0", ifa.stall_cycles); end
        n_cmp++; if (ifa.err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", ifa.err); end
        n_cmp++; if (ifa.ForwardAE !== 2'b10) begin n_bad++; $display("FAIL reset_fwd: got %b expected 10", ifa.ForwardAE); end
        step();
        step();
        n_cmp++; if (ifa.stall_cycles !== 32'd0) begin n_bad++; $display("FAIL reset_hold_cnt: got %0d expected 0", ifa.stall_cycles); end
        set_idle();
        #2;
        reset = 0;
        step();
    endtask

    task automatic test_forwarding();
        set_idle();
        rdM = 5; RegWriteM = 1; rdW = 5; RegWriteW = 1; rs1E = 5; rs2E = 0;
        #1;
        n_cmp++; if (ifa.ForwardAE !== 2'b10) begin n_bad++; $display("FAIL fwd_m_prio: got %b expected 10", ifa.ForwardAE); end
        n_cmp++; if (ifa.ForwardBE !== 2'b00) begin n_bad++; $display("FAIL fwd_x0: got %b expected 00", ifa.ForwardBE); end
        RegWriteM = 0;
        #1;
        n_cmp++; if (ifa.ForwardAE !== 2'b01) begin n_bad++; $display("FAIL fwd_w: got %b expected 01", ifa.ForwardAE); end
        rs2E = 5; RegWriteM = 1; rdM = 6;
        #1;
        n_cmp++; if (ifa.ForwardBE !== 2'b01) begin n_bad++; $display("FAIL fwd_b_w: got %b expected 01", ifa.ForwardBE); end
        rs1E = 6;
        #1;
        n_cmp++; if (ifa.ForwardAE !== 2'b10) begin n_bad++; $display("FAIL fwd_a_m: got %b expected 10", ifa.ForwardAE); end
        set_idle();
        step();
    endtask

    task automatic test_load_use();
        do_reset();
        ResultSrcE0 = 1; rdE = 7; rs2D = 7;
        #1;
        n_cmp++; if (ctl_a !== 7'b0011_010) begin n_bad++; $display("FAIL lw_ctl: got %b expected %b", ctl_a, 7'b0011_010); end
        step();
        ResultSrcE0 = 0;
        #1;
        n_cmp++; if (ifa.stall_cycles !== 32'd1) begin n_bad++; $display("FAIL lw_cnt: got %0d expected 1", ifa.stall_cycles); end
        n_cmp++; if (ctl_a !== 7'b1111_000) begin n_bad++; $display("FAIL lw_release: got %b expected %b", ctl_a, 7'b1111_000); end
        ResultSrcE0 = 1; rdE = 0; rs2D = 0;
        #1;
        n_cmp++; if (ctl_a !== 7'b1111_000) begin n_bad++; $display("FAIL lw_x0: got %b expected %b", ctl_a, 7'b1111_000); end
        step();
        n_cmp++; if (ifa.stall_cycles !== 32'd1) begin n_bad++; $display("FAIL lw_x0_cnt: got %0d expected 1", ifa.stall_cycles); end
        set_idle();
    endtask

    task automatic test_branch_vs_load();
        do_reset();
        ResultSrcE0 = 1; rdE = 7; rs1D = 7; PCSrcE = 1;
        #1;
        n_cmp++; if (ctl_a !== 7'b1111_110) begin n_bad++; $display("FAIL br_lw_ctl: got %b expected %b", ctl_a, 7'b1111_110); end
        step();
        n_cmp++; if (ifa.stall_cycles !== 32'd0) begin n_bad++; $display("FAIL br_lw_cnt: got %0d expected 0", ifa.stall_cycles); end
        set_idle();
    endtask

    task automatic test_mem_wait();
        do_reset();
        MemAccessM = 1; mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            PCSrcE = (i == 1);
            #1;
            n_cmp++; if (ctl_a !== 7'b0000_001) begin n_bad++; $display("FAIL memwait_ctl[%0d]: got %b expected %b", i, ctl_a, 7'b0000_001); end
            step();
        end
        PCSrcE = 0; mem_ready = 1;
        #1;
        n_cmp++; if (ctl_a !== 7'b1111_000) begin n_bad++; $display("FAIL memwait_retire: got %b expected %b", ctl_a, 7'b1111_000); end
        step();
        MemAccessM = 0; mem_ready = 0;
        #1;
        n_cmp++; if (ifa.stall_cycles !== 32'd3) begin n_bad++; $display("FAIL memwait_cnt: got %0d expected 3", ifa.stall_cycles); end
        n_cmp++; if (ifb.err !== 1'b0) begin n_bad++; $display("FAIL memwait_err: got %b expected 0", ifb.err); end
        MemAccessM = 1;
        for (int i = 0; i < TB; i++) step();
        mem_ready = 1;
        step();
        n_cmp++; if (ifb.err !== 1'b0) begin n_bad++; $display("FAIL memwait_rerun_err: got %b expected 0", ifb.err); end
        set_idle();
    endtask

    task automatic test_timeout();
        do_reset();
        MemAccessM = 1; mem_ready = 0;
        for (int i = 0; i < TB + 1; i++) begin
            #1;
            n_cmp++; if (ifb.err !== 1'b0 || ctl_b !== 7'b0000_001) begin n_bad++; $display("FAIL tmo_wait[%0d]: got err=%b ctl=%b expected err=0 ctl=0000001", i, ifb.err, ctl_b); end
            step();
        end
        n_cmp++; if (ifb.err !== 1'b1) begin n_bad++; $display("FAIL tmo_err: got %b expected 1", ifb.err); end
        n_cmp++; if (ctl_b !== 7'b0) begin n_bad++; $display("FAIL tmo_ctl: got %b expected 0000000", ctl_b); end
        n_cmp++; if (ifb.stall_cycles !== 4'd5) begin n_bad++; $display("FAIL tmo_cnt: got %0d expected 5", ifb.stall_cycles); end
        n_cmp++; if (ifa.err !== 1'b0) begin n_bad++; $display("FAIL tmo_a_err: got %b expected 0", ifa.err); end
        mem_ready = 1;
        step();
        n_cmp++; if (ifb.err !== 1'b1 || ctl_b !== 7'b0) begin n_bad++; $display("FAIL tmo_sticky: got err=%b ctl=%b expected err=1 ctl=0000000", ifb.err, ctl_b); end
        n_cmp++; if (ifb.stall_cycles !== 4'd6) begin n_bad++; $display("FAIL tmo_err_cnt: got %0d expected 6", ifb.stall_cycles); end
        reset = 1;
        #1;
        n_cmp++; if (ifb.err !== 1'b0 || ctl_b !== 7'b1111_000) begin n_bad++; $display("FAIL tmo_async_rst: got err=%b ctl=%b expected err=0 ctl=1111000", ifb.err, ctl_b); end
        n_cmp++; if (ifb.stall_cycles !== 4'd0) begin n_bad++; $display("FAIL tmo_async_cnt: got %0d expected 0", ifb.stall_cycles); end
        set_idle();
        #1;
        reset = 0;
        step();
    endtask

    task automatic test_saturation();
        do_reset();
        ResultSrcE0 = 1; rdE = 9; rs1D = 9;
        repeat (20) step();
        n_cmp++; if (ifb.stall_cycles !== 4'd15) begin n_bad++; $display("FAIL sat_b: got %0d expected 15", ifb.stall_cycles); end
        n_cmp++; if (ifa.stall_cycles !== 32'd20) begin n_bad++; $display("FAIL sat_a: got %0d expected 20", ifa.stall_cycles); end
        step();
        n_cmp++; if (ifb.stall_cycles !== 4'd15) begin n_bad++; $display("FAIL sat_hold: got %0d expected 15", ifb.stall_cycles); end
        set_idle();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            rs1D = 5'($urandom_range(0, 3)); rs2D = 5'($urandom_range(0, 3));
            rs1E = 5'($urandom_range(0, 3)); rs2E = 5'($urandom_range(0, 3));
            rdE = 5'($urandom_range(0, 3)); rdM = 5'($urandom_range(0, 3)); rdW = 5'($urandom_range(0, 3));
            ResultSrcE0 = $urandom_range(0, 1) == 1; RegWriteM = $urandom_range(0, 1) == 1;
            RegWriteW = $urandom_range(0, 1) == 1; PCSrcE = $urandom_range(0, 3) == 0;
            MemAccessM = $urandom_range(0, 9) < 6; mem_ready = $urandom_range(0, 9) < 4;
            if ($urandom_range(0, 79) == 0) begin
                reset = 1;
                #1;
                reset = 0;
            end
            #1;
            n_cmp++; if (ctl_a !== exp_ctl(m_err_a)) begin n_bad++; $display("FAIL rnd_ctl_a[%0d]: got %b expected %b", i, ctl_a, exp_ctl(m_err_a)); end
            n_cmp++; if (ctl_b !== exp_ctl(m_err_b)) begin n_bad++; $display("FAIL rnd_ctl_b[%0d]: got %b expected %b", i, ctl_b, exp_ctl(m_err_b)); end
            n_cmp++; if (ifa.ForwardAE !== exp_fwd(rs1E) || ifa.ForwardBE !== exp_fwd(rs2E)) begin n_bad++; $display("FAIL rnd_fwd[%0d]: got %b/%b expected %b/%b", i, ifa.ForwardAE, ifa.ForwardBE, exp_fwd(rs1E), exp_fwd(rs2E)); end
            n_cmp++; if (ifa.err !== m_err_a || ifb.err !== m_err_b) begin n_bad++; $display("FAIL rnd_err[%0d]: got %b/%b expected %b/%b", i, ifa.err, ifb.err, m_err_a, m_err_b); end
            n_cmp++; if (ifa.stall_cycles !== m_cnt_a || ifb.stall_cycles !== m_cnt_b) begin n_bad++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d expected %0d/%0d", i, ifa.stall_cycles, ifb.stall_cycles, m_cnt_a, m_cnt_b); end
            step();
        end
        set_idle();
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch_vs_load();
        test_mem_wait();
        test_timeout();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
